nubus_cpu_bridge: RTL and testbench

- Sits between a PicoRV32-style processor memory port and the processor port of the NuBus interface top.
- Latches one processor request and holds it stable on the master-side port until the NuBus transaction ends.
- Decodes the NuBus acknowledge status and retries try-again-later responses with a back-off gap.
- Applies a local watchdog timeout, then returns data or error to the processor with a single-cycle ready pulse.

---
 rtl/nubus_cpu_bridge.sv | 168 ++++++++++++++++
 tb/tb_nubus_cpu_bridge.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/nubus_cpu_bridge.sv
// Bridges a PicoRV32-style memory port onto the NuBus master request port.
// Holds one request stable, retries try-again-later acks, and applies a local watchdog.
module nubus_cpu_bridge #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 3,
  parameter int RETRY_GAP      = 4
) (
  input  logic        nub_clkn,
  input  logic        nub_resetn,
  input  logic        pcpu_valid,
  input  logic [31:0] pcpu_addr,
  input  logic [31:0] pcpu_wdata,
  input  logic [3:0]  pcpu_wstrb,
  input  logic        pcpu_lock,
  output logic        pcpu_ready,
  output logic [31:0] pcpu_rdata,
  output logic        pcpu_error,
  output logic        mst_valid,
  output logic [31:0] mst_addr,
  output logic [31:0] mst_wdata,
  output logic [3:0]  mst_write,
  output logic        mst_lock,
  input  logic        mst_ready,
  input  logic [31:0] mst_rdata,
  input  logic [1:0]  mst_status
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GAP_W = (RETRY_GAP > 0) ? $clog2(RETRY_GAP + 1) : 1;

  localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_SAT  = '1;
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(RETRY_GAP);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_BACKOFF = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  // All state advances on the falling edge of the NuBus clock.
  logic clk;
  assign clk = ~nub_clkn;

  logic [1:0]       state_reg, state_next;
  logic [31:0]      addr_reg, addr_next;
  logic [31:0]      wdata_reg, wdata_next;
  logic [3:0]       wstrb_reg, wstrb_next;
  logic             lock_reg, lock_next;
  logic [31:0]      rdata_reg, rdata_next;
  logic             err_reg, err_next;
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [RTY_W-1:0] retry_cnt_reg, retry_cnt_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    lock_next      = lock_reg;
    rdata_next     = rdata_reg;
    err_next       = err_reg;
    tmo_cnt_next   = tmo_cnt_reg;
    retry_cnt_next = retry_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (pcpu_valid) begin
          addr_next      = pcpu_addr;
          wdata_next     = pcpu_wdata;
          wstrb_next     = pcpu_wstrb;
          lock_next      = pcpu_lock;
          retry_cnt_next = '0;
          tmo_cnt_next   = '0;
          state_next     = S_REQ;
        end
      end
      S_REQ: begin
        if (tmo_cnt_reg != TMO_SAT) tmo_cnt_next = tmo_cnt_reg + 1'b1;
        // An acknowledge on the watchdog's terminal cycle takes priority.
        if (mst_ready) begin
          case (mst_status)
            2'b00: begin
              rdata_next = (wstrb_reg == 4'b0000) ? mst_rdata : 32'h0;
              err_next   = 1'b0;
              state_next = S_RESP;
            end
            2'b11: begin
              if (retry_cnt_reg < RTY_MAX) begin
                retry_cnt_next = retry_cnt_reg + 1'b1;
                gap_cnt_next   = GAP_LOAD;
                state_next     = S_BACKOFF;
              end else begin
                rdata_next = 32'h0;
                err_next   = 1'b1;
                state_next = S_RESP;
              end
            end
            default: begin
              rdata_next = 32'h0;
              err_next   = 1'b1;
              state_next = S_RESP;
            end
          endcase
        end else if (TMO_EN && (tmo_cnt_reg == TMO_LAST)) begin
          rdata_next = 32'h0;
          err_next   = 1'b1;
          state_next = S_RESP;
        end
      end
      S_BACKOFF: begin
        if (gap_cnt_reg == GAP_ONE) begin
          tmo_cnt_next = '0;
          state_next   = S_REQ;
        end else begin
          gap_cnt_next = gap_cnt_reg - 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nub_resetn) begin
    if (!nub_resetn) begin
      state_reg     <= S_IDLE;
      addr_reg      <= 32'h0;
      wdata_reg     <= 32'h0;
      wstrb_reg     <= 4'h0;
      lock_reg      <= 1'b0;
      rdata_reg     <= 32'h0;
      err_reg       <= 1'b0;
      tmo_cnt_reg   <= '0;
      retry_cnt_reg <= '0;
      gap_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      lock_reg      <= lock_next;
      rdata_reg     <= rdata_next;
      err_reg       <= err_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      retry_cnt_reg <= retry_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
    end
  end

  // Outputs decode from registered state so reset clears them immediately.
  logic busy;
  logic in_resp;
  assign busy    = (state_reg != S_IDLE);
  assign in_resp = (state_reg == S_RESP);

  assign mst_valid  = (state_reg == S_REQ);
  assign mst_addr   = busy ? addr_reg  : 32'h0;
  assign mst_wdata  = busy ? wdata_reg : 32'h0;
  assign mst_write  = busy ? wstrb_reg : 4'h0;
  assign mst_lock   = busy & lock_reg;
  assign pcpu_ready = in_resp;
  assign pcpu_rdata = in_resp ? rdata_reg : 32'h0;
  assign pcpu_error = in_resp & err_reg;

endmodule

// File: tb/tb_nubus_cpu_bridge.sv
// Directed bench for nubus_cpu_bridge: scripted NuBus responder, retry/timeout/reset cases.
module tb_nubus_cpu_bridge;

  logic        nub_clkn;
  logic        nub_resetn;
  logic        pcpu_valid;
  logic [31:0] pcpu_addr;
  logic [31:0] pcpu_wdata;
  logic [3:0]  pcpu_wstrb;
  logic        pcpu_lock;
  logic        pcpu_ready;
  logic [31:0] pcpu_rdata;
  logic        pcpu_error;
  logic        mst_valid;
  logic [31:0] mst_addr;
  logic [31:0] mst_wdata;
  logic [3:0]  mst_write;
  logic        mst_lock;
  logic        mst_ready;
  logic [31:0] mst_rdata;
  logic [1:0]  mst_status;

  int total = 0;
  int bad   = 0;

  nubus_cpu_bridge #(
    .TIMEOUT_CYCLES(8),
    .MAX_RETRY(3),
    .RETRY_GAP(4)
  ) dut (
    .nub_clkn(nub_clkn),
    .nub_resetn(nub_resetn),
    .pcpu_valid(pcpu_valid),
    .pcpu_addr(pcpu_addr),
    .pcpu_wdata(pcpu_wdata),
    .pcpu_wstrb(pcpu_wstrb),
    .pcpu_lock(pcpu_lock),
    .pcpu_ready(pcpu_ready),
    .pcpu_rdata(pcpu_rdata),
    .pcpu_error(pcpu_error),
    .mst_valid(mst_valid),
    .mst_addr(mst_addr),
    .mst_wdata(mst_wdata),
    .mst_write(mst_write),
    .mst_lock(mst_lock),
    .mst_ready(mst_ready),
    .mst_rdata(mst_rdata),
    .mst_status(mst_status)
  );

  initial nub_clkn = 1'b1;
  always #5 nub_clkn = ~nub_clkn;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Step past the active (falling) edge; drive and sample here.
  task automatic tick();
    @(negedge nub_clkn);
    #1;
  endtask

  task automatic do_reset(input string tag);
    #3 nub_resetn = 1'b0;
    #1;
    chk({tag, ".rst_valid"}, mst_valid, 1'b0);
    chk({tag, ".rst_lock"}, mst_lock, 1'b0);
    chk({tag, ".rst_write"}, mst_write, 4'h0);
    chk({tag, ".rst_addr"}, mst_addr, 32'h0);
    chk({tag, ".rst_wdata"}, mst_wdata, 32'h0);
    chk({tag, ".rst_ready"}, pcpu_ready, 1'b0);
    pcpu_valid = 1'b0;
    mst_ready  = 1'b0;
    tick();
    tick();
    #2 nub_resetn = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk({tag, ".post_ready"}, pcpu_ready, 1'b0);
      chk({tag, ".post_valid"}, mst_valid, 1'b0);
      tick();
    end
    $display("txn %s: reset applied mid-transaction", tag);
  endtask

  // Issue one request and act as the NuBus responder until pcpu_ready.
  task automatic do_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic lock, input int n_tal,
                        input logic [1:0] fin_st, input int ack_dly, input bit no_ack,
                        input logic [31:0] rd, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_run, input int rst_cyc);
    int  run;
    int  gap;
    int  tals;
    bit  done;
    bit  was_valid;
    pcpu_valid = 1'b1;
    pcpu_addr  = addr;
    pcpu_wdata = wdata;
    pcpu_wstrb = wstrb;
    pcpu_lock  = lock;
    tick();
    // Scramble the processor side; the bridge must keep the latched copy.
    pcpu_addr  = ~addr;
    pcpu_wdata = ~wdata;
    pcpu_wstrb = ~wstrb;
    pcpu_lock  = ~lock;
    chk({tag, ".rise"}, mst_valid, 1'b1);
    run = 0; gap = 0; tals = 0; done = 0; was_valid = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (cyc == rst_cyc) begin
        do_reset(tag);
        return;
      end
      mst_ready  = 1'b0;
      mst_status = 2'b00;
      mst_rdata  = 32'h0;
      if (pcpu_ready) begin
        chk({tag, ".rdata"}, pcpu_rdata, exp_rdata);
        chk({tag, ".err"}, pcpu_error, exp_err);
        chk({tag, ".run"}, run, exp_run);
        chk({tag, ".lat"}, was_valid, 1'b1);
        pcpu_valid = 1'b0;
        done = 1;
        $display("txn %s: addr=%h wstrb=%b retries=%0d rdata=%h err=%0d",
                 tag, addr, wstrb, tals, pcpu_rdata, pcpu_error);
      end else if (mst_valid) begin
        if (gap != 0) begin
          chk({tag, ".gap"}, gap, 4);
          gap = 0;
          run = 0;
        end
        chk({tag, ".addr"}, mst_addr, addr);
        chk({tag, ".wdata"}, mst_wdata, wdata);
        chk({tag, ".write"}, mst_write, wstrb);
        chk({tag, ".lock"}, mst_lock, lock);
        if (!no_ack && run == ack_dly) begin
          mst_ready  = 1'b1;
          mst_status = (tals < n_tal) ? 2'b11 : fin_st;
          mst_rdata  = rd;
          if (tals < n_tal) tals++;
        end else begin
          mst_rdata = 32'h5555AAAA;
        end
        run++;
      end else begin
        // Back-off: an acknowledge here must be ignored.
        gap++;
        chk({tag, ".bo_lock"}, mst_lock, lock);
        chk({tag, ".bo_addr"}, mst_addr, addr);
        mst_ready = 1'b1;
        mst_rdata = 32'hBAD0BAD0;
      end
      was_valid = mst_valid;
      tick();
    end
    if (!done) chk({tag, ".wait_expired"}, 32'h0, 32'h1);
    chk({tag, ".pulse"}, pcpu_ready, 1'b0);
    chk({tag, ".idle_valid"}, mst_valid, 1'b0);
  endtask

  initial begin
    nub_resetn = 1'b0;
    pcpu_valid = 1'b0;
    pcpu_addr  = 32'h0;
    pcpu_wdata = 32'h0;
    pcpu_wstrb = 4'h0;
    pcpu_lock  = 1'b0;
    mst_ready  = 1'b0;
    mst_rdata  = 32'h0;
    mst_status = 2'b00;
    tick();
    tick();
    chk("reset.valid", mst_valid, 1'b0);
    chk("reset.ready", pcpu_ready, 1'b0);
    chk("reset.error", pcpu_error, 1'b0);
    chk("reset.rdata", pcpu_rdata, 32'h0);
    chk("reset.addr", mst_addr, 32'h0);
    chk("reset.write", mst_write, 4'h0);
    #2 nub_resetn = 1'b1;
    tick();

    //     tag       addr          wdata         wstrb    lk  tal st     dly noack rd            exp_rdata     err  run rst
    do_txn("read",   32'h00001000, 32'h00000000, 4'b0000, 0,  0, 2'b00, 1,  0,  32'hDEADBEEF, 32'hDEADBEEF, 0,   2, -1);
    do_txn("write",  32'hF9000010, 32'h12345678, 4'b0011, 0,  0, 2'b00, 0,  0,  32'hCAFEF00D, 32'h00000000, 0,   1, -1);
    do_txn("tal3",   32'hF9000020, 32'h00000000, 4'b0000, 1,  3, 2'b00, 0,  0,  32'h0A5A5A5A, 32'h0A5A5A5A, 0,   1, -1);
    do_txn("tal4",   32'hF9000030, 32'h00000000, 4'b0000, 0,  4, 2'b00, 0,  0,  32'h11112222, 32'h00000000, 1,   1, -1);
    do_txn("tmo",    32'hF9000040, 32'h00000000, 4'b0000, 0,  0, 2'b00, 0,  1,  32'h33334444, 32'h00000000, 1,   8, -1);
    do_txn("tmo_rdy",32'hF9000050, 32'h00000000, 4'b0000, 0,  0, 2'b00, 7,  0,  32'h76543210, 32'h76543210, 0,   8, -1);
    do_txn("st01",   32'hF9000060, 32'h00000000, 4'b0000, 0,  0, 2'b01, 2,  0,  32'hFFFFFFFF, 32'h00000000, 1,   3, -1);
    do_txn("st10",   32'hF9000070, 32'hABCDEF01, 4'b1111, 0,  0, 2'b10, 0,  0,  32'hFFFFFFFF, 32'h00000000, 1,   1, -1);
    do_txn("rst_req",32'hF9000080, 32'h00000000, 4'b0000, 1,  0, 2'b00, 5,  0,  32'h0,        32'h0,        0,   0,  2);
    do_txn("rst_bo", 32'hF9000090, 32'h00000000, 4'b0000, 1,  1, 2'b00, 0,  0,  32'h0,        32'h0,        0,   0,  2);
    do_txn("after",  32'hA0000004, 32'h00000000, 4'b0000, 0,  0, 2'b00, 0,  0,  32'hA0A0A0A0, 32'hA0A0A0A0, 0,   1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit got=hung exp=finished");
    $fatal(1, "time limit");
  end

endmodule
